// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forwarding encoding, pipeline action and width helpers.
// Pure declarations, no logic.
package pipe_hazard_ctrl_pkg;

    localparam int FWD_RF = 0;

    // One action per cycle; earlier entries in the priority order win.
    typedef enum logic [1:0] {
        ACT_RUN    = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_FREEZE = 2'd3
    } hz_act_e;

    function automatic int calc_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    function automatic int calc_sw(input int nstages);
        return $clog2(nstages + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_match.sv
// Youngest-writer priority encoder: returns the smallest stage number whose entry writes src and
// is qualified, or FWD_RF when none does. Purely combinational, no backpressure.
module pipe_hazard_ctrl_hz_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = 3,
    parameter int SW = 2
) (
    input  logic                  en,
    input  logic [AW-1:0]         src,
    input  logic [N-1:0]          vld,
    input  logic [N-1:0]          wren,
    input  logic [N-1:0]          qual,
    input  logic [N-1:0][AW-1:0]  waddr,
    output logic [SW-1:0]         sel
);

    // Scan oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        sel = SW'(FWD_RF);
        if (en) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vld[i] && wren[i] && qual[i] && (waddr[i] == src)) begin
                    sel = SW'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: stall, bubble, flush and kill for the front end plus EX forwarding selects.
// Controls are combinational from entries and ID; entries and counters update on the next clk edge.
// mem_busy freezes every entry and the front end; taken branches override load-use stalls.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGES    = 3,
    parameter int NREGS      = 8,
    parameter int LOAD_AVAIL = 2,
    parameter int BR_STAGE   = 2,
    parameter int CW         = 16,
    localparam int AW        = calc_aw(NREGS),
    localparam int SW        = calc_sw(NSTAGES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [AW-1:0]      id_rs1,
    input  logic [AW-1:0]      id_rs2,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic               id_wren,
    input  logic [AW-1:0]      id_waddr,
    input  logic               id_is_load,
    input  logic               br_taken,
    input  logic               mem_busy,
    output logic               pc_wr,
    output logic               ifid_wr,
    output logic               bubble,
    output logic               flush_ifid,
    output logic [NSTAGES-1:0] kill,
    output logic [SW-1:0]      fwd_a,
    output logic [SW-1:0]      fwd_b,
    output logic [CW-1:0]      stall_cnt,
    output logic [CW-1:0]      flush_cnt
);

    // Per-stage entries; index k-1 holds stage k. Source fields exist only for stage 1 (EX).
    logic [NSTAGES-1:0]         ent_v;
    logic [NSTAGES-1:0]         ent_wren;
    logic [NSTAGES-1:0]         ent_load;
    logic [NSTAGES-1:0][AW-1:0] ent_waddr;
    logic [AW-1:0]              ex_rs1;
    logic [AW-1:0]              ex_rs2;
    logic                       ex_rs1_used;
    logic                       ex_rs2_used;

    logic [NSTAGES-1:0] lu_qual;
    logic [NSTAGES-1:0] fwd_qual;
    logic [NSTAGES-1:0] kill_mask;
    logic [SW-1:0]      lu_sel_a;
    logic [SW-1:0]      lu_sel_b;
    logic               lu;
    hz_act_e            act;

    // A load in stage k feeds a consumer now in ID only once it reaches stage k+1; stage 1 loads always stall.
    always_comb begin
        lu_qual   = '0;
        fwd_qual  = '0;
        kill_mask = '0;
        for (int k = 1; k <= NSTAGES; k++) begin
            lu_qual[k-1]   = ent_load[k-1] && ((k == 1) || (k + 1 < LOAD_AVAIL));
            fwd_qual[k-1]  = (k >= 2) && !(ent_load[k-1] && (k < LOAD_AVAIL));
            kill_mask[k-1] = (k < BR_STAGE);
        end
    end

    pipe_hazard_ctrl_hz_match #(.N(NSTAGES), .AW(AW), .SW(SW)) u_lu_a (
        .en    (id_valid && id_rs1_used),
        .src   (id_rs1),
        .vld   (ent_v),
        .wren  (ent_wren),
        .qual  (lu_qual),
        .waddr (ent_waddr),
        .sel   (lu_sel_a)
    );

    pipe_hazard_ctrl_hz_match #(.N(NSTAGES), .AW(AW), .SW(SW)) u_lu_b (
        .en    (id_valid && id_rs2_used),
        .src   (id_rs2),
        .vld   (ent_v),
        .wren  (ent_wren),
        .qual  (lu_qual),
        .waddr (ent_waddr),
        .sel   (lu_sel_b)
    );

    pipe_hazard_ctrl_hz_match #(.N(NSTAGES), .AW(AW), .SW(SW)) u_fwd_a (
        .en    (ent_v[0] && ex_rs1_used),
        .src   (ex_rs1),
        .vld   (ent_v),
        .wren  (ent_wren),
        .qual  (fwd_qual),
        .waddr (ent_waddr),
        .sel   (fwd_a)
    );

    pipe_hazard_ctrl_hz_match #(.N(NSTAGES), .AW(AW), .SW(SW)) u_fwd_b (
        .en    (ent_v[0] && ex_rs2_used),
        .src   (ex_rs2),
        .vld   (ent_v),
        .wren  (ent_wren),
        .qual  (fwd_qual),
        .waddr (ent_waddr),
        .sel   (fwd_b)
    );

    assign lu = (lu_sel_a != SW'(FWD_RF)) || (lu_sel_b != SW'(FWD_RF));

    // Held in reset the front end sees an empty, free-running pipe regardless of busy/branch inputs.
    always_comb begin
        if (!rst_n) begin
            act = ACT_RUN;
        end else if (mem_busy) begin
            act = ACT_FREEZE;
        end else if (br_taken) begin
            act = ACT_FLUSH;
        end else if (lu) begin
            act = ACT_STALL;
        end else begin
            act = ACT_RUN;
        end
    end

    always_comb begin
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        kill       = '0;
        case (act)
            ACT_FREEZE: begin
                pc_wr   = 1'b0;
                ifid_wr = 1'b0;
            end
            ACT_FLUSH: begin
                bubble     = 1'b1;
                flush_ifid = 1'b1;
                kill       = kill_mask;
            end
            ACT_STALL: begin
                pc_wr   = 1'b0;
                ifid_wr = 1'b0;
                bubble  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v       <= '0;
            ent_wren    <= '0;
            ent_load    <= '0;
            ent_waddr   <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_used <= 1'b0;
            ex_rs2_used <= 1'b0;
        end else if (act != ACT_FREEZE) begin
            for (int k = NSTAGES; k >= 2; k--) begin
                ent_v[k-1]     <= ent_v[k-2] && !((act == ACT_FLUSH) && (k < BR_STAGE));
                ent_wren[k-1]  <= ent_wren[k-2];
                ent_load[k-1]  <= ent_load[k-2];
                ent_waddr[k-1] <= ent_waddr[k-2];
            end
            ent_v[0]     <= id_valid && (act == ACT_RUN);
            ent_wren[0]  <= id_wren;
            ent_load[0]  <= id_is_load;
            ent_waddr[0] <= id_waddr;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rs1_used  <= id_rs1_used;
            ex_rs2_used  <= id_rs2_used;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (((act == ACT_FREEZE) || (act == ACT_STALL)) && (stall_cnt != {CW{1'b1}})) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if ((act == ACT_FLUSH) && (flush_cnt != {CW{1'b1}})) begin
                flush_cnt <= flush_cnt + CW'(1);
            end
        end
    end

endmodule
